// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Desc     : Shared AES-128 types, round constants, S-box and byte-order helpers.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS_MAX = 10;

    // Row-major: index 15-4r-c holds row r, column c.
    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_t;

    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Bus byte k maps to row k%4, column k/4.
    function automatic aes_state_t bus_to_state(input logic [127:0] bus);
        aes_state_t s;
        for (int k = 0; k < 16; k++)
            s[15-4*(k%4)-(k/4)] = bus[127-8*k -: 8];
        return s;
    endfunction

    function automatic logic [127:0] state_to_bus(input aes_state_t s);
        logic [127:0] bus;
        for (int k = 0; k < 16; k++)
            bus[127-8*k -: 8] = s[15-4*(k%4)-(k/4)];
        return bus;
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++)
            o[i] = sbox(s[i]);
        return o;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[15-4*r-c] = s[15-4*r-((c+r)%4)];
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_step
// Desc     : Combinational single-round AES-128 key expansion (bus byte order).
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_key
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_rot = {i_key[23:0], i_key[31:24]};
    assign w_sub = {sbox(w_rot[31:24]) ^ i_rcon, sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]), sbox(w_rot[7:0])};

    assign w_n0  = i_key[127:96] ^ w_sub;
    assign w_n1  = i_key[95:64]  ^ w_n0;
    assign w_n2  = i_key[63:32]  ^ w_n1;
    assign w_n3  = i_key[31:0]   ^ w_n2;
    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/mixColumns.sv
`default_nettype none
// ============================================================================
// Module   : mixColumns
// Desc     : Combinational AES MixColumns over a row-major [15:0][7:0] state.
// Revision : 1.0 - initial release
// ============================================================================
module mixColumns
    import aes_pkg::*;
(
    input  aes_state_t i_state,
    output aes_state_t o_state
);

    genvar c;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = i_state[15-c];
            assign w_a1 = i_state[11-c];
            assign w_a2 = i_state[7-c];
            assign w_a3 = i_state[3-c];
            assign o_state[15-c] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign o_state[11-c] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign o_state[7-c]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign o_state[3-c]  = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Desc     : Iterative AES-128 encryptor, one round per clock, valid/ready I/O.
//            Optional AES_ROUND_OBS_EN adds round_dbg/busy observation ports.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_MAX
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out
`ifdef AES_ROUND_OBS_EN
    ,
    output logic [3:0]   round_dbg,
    output logic         busy
`endif
);

    aes_fsm_t     r_fsm, w_fsm_nxt;
    logic [3:0]   r_round_cnt, w_cnt_nxt;
    aes_state_t   r_state, w_state_nxt;
    logic [127:0] r_rkey, w_rkey_load;
    logic         r_in_ready, r_out_valid;

    logic [127:0] w_rkey_nxt;
    aes_state_t   w_sr, w_mc, w_round_out;
    logic         w_last;

    assign w_last = (r_round_cnt == 4'(NUM_ROUNDS));

    aes_key_step u_key_step (
        .i_key  (r_rkey),
        .i_rcon (RCON[r_round_cnt]),
        .o_key  (w_rkey_nxt)
    );

    assign w_sr = shift_rows(sub_bytes(r_state));

    mixColumns u_mix (
        .i_state (w_sr),
        .o_state (w_mc)
    );

    // Final round skips MixColumns.
    assign w_round_out = (w_last ? w_sr : w_mc) ^ bus_to_state(w_rkey_nxt);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_round_cnt;
        w_state_nxt = r_state;
        w_rkey_load = r_rkey;
        case (r_fsm)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_fsm_nxt   = ROUND;
                    w_state_nxt = bus_to_state(pt_in ^ key_in);
                    w_rkey_load = key_in;
                    w_cnt_nxt   = 4'd1;
                end
            end
            ROUND: begin
                w_state_nxt = w_round_out;
                w_rkey_load = w_rkey_nxt;
                if (w_last)
                    w_fsm_nxt = DONE;
                else
                    w_cnt_nxt = r_round_cnt + 4'd1;
            end
            DONE: begin
                if (out_ready)
                    w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_round_cnt <= 4'd0;
            r_state     <= '0;
            r_rkey      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_round_cnt <= w_cnt_nxt;
            r_state     <= w_state_nxt;
            r_rkey      <= w_rkey_load;
            r_in_ready  <= (w_fsm_nxt == IDLE);
            r_out_valid <= (w_fsm_nxt == DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ct_out    = state_to_bus(r_state);

`ifdef AES_ROUND_OBS_EN
    logic [3:0] r_round_dbg;
    logic       r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_round_dbg <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            r_round_dbg <= (w_fsm_nxt == ROUND) ? w_cnt_nxt : 4'd0;
            r_busy      <= (w_fsm_nxt == ROUND);
        end
    end

    assign round_dbg = r_round_dbg;
    assign busy      = r_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Desc     : Self-checking bench; byte-array AES reference with a GF(2^8)-derived S-box.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] pt_in = '0;
    logic [127:0] key_in = '0;
    logic         in_ready, out_valid;
    logic [127:0] ct_out;
`ifdef AES_ROUND_OBS_EN
    logic [3:0]   round_dbg;
    logic         busy;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] sb [256];

    aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_in     (pt_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out)
`ifdef AES_ROUND_OBS_EN
        ,
        .round_dbg (round_dbg),
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box = affine(multiplicative inverse), inverse computed as x^254.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard FIPS-197 column-major byte array: s[k] is row k%4, column k/4.
    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp = '{sb[w[i-1][1]] ^ rc, sb[w[i-1][2]], sb[w[i-1][3]], sb[w[i-1][0]]};
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int k = 0; k < 16; k++) s[k] ^= w[k/4][k%4];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r+4*c] = sb[s[r+4*((c+r)%4)]];
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            for (int k = 0; k < 16; k++) s[k] ^= w[4*rd + k/4][k%4];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // acc = cycle count right after the accepting edge, -1 on timeout.
    task automatic send(input logic [127:0] pt, input logic [127:0] key, output int acc);
        bit rdy;
        acc = -1;
        pt_in = pt; key_in = key; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        pt_in = rnd128();
        key_in = rnd128();
    endtask

    task automatic wait_valid(output bit ok, output int vcyc, output logic [127:0] ct);
        ok = 1'b0; vcyc = -1; ct = '0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1; vcyc = cyc; ct = ct_out;
                return;
            end
            tick();
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || ct_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b ct=%h, required 0 0 0", in_ready, out_valid, ct_out);
        end
`ifdef AES_ROUND_OBS_EN
        checks++;
        if (busy !== 1'b0 || round_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_obs: busy=%b round_dbg=%0d, required 0 0", busy, round_dbg);
        end
`endif
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_kat();
        int acc, vcyc; bit ok; logic [127:0] ct;
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, acc);
        wait_valid(ok, vcyc, ct);
        checks++;
        if (!ok || ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++;
            $display("FAIL kat_c1: got %h (valid=%b), required 69c4e0d86a7b0430d8cdb78070b4c55a", ct, ok);
        end
        // out_valid rises on the 11th edge counting the accept edge itself.
        checks++;
        if (acc < 0 || !ok || vcyc - acc !== NR) begin
            errors++;
            $display("FAIL kat_c1_latency: got %0d edges after accept, required %0d", vcyc - acc, NR);
        end
        ack();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kat_c1_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, acc);
        wait_valid(ok, vcyc, ct);
        checks++;
        if (!ok || ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin
            errors++;
            $display("FAIL kat_b: got %h (valid=%b), required 3925841d02dc09fbdc118597196a0b32", ct, ok);
        end
        ack();
    endtask

    task automatic test_random();
        int acc, vcyc; bit ok; logic [127:0] ct, pt, key, exp;
        for (int j = 0; j < 8; j++) begin
            pt = rnd128(); key = rnd128();
            exp = aes_model(pt, key, NR);
            repeat ($urandom_range(0, 3)) tick();
            send(pt, key, acc);
            wait_valid(ok, vcyc, ct);
            repeat ($urandom_range(0, 4)) tick();
            checks++;
            if (!ok || ct_out !== exp) begin
                errors++;
                $display("FAIL random_job%0d: got %h (valid=%b), required %h", j, ct_out, ok, exp);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int acc, vcyc; bit ok; logic [127:0] ct0, pt, key, exp;
        pt = rnd128(); key = rnd128();
        exp = aes_model(pt, key, NR);
        send(pt, key, acc);
        wait_valid(ok, vcyc, ct0);
        checks++;
        if (!ok || ct0 !== exp) begin
            errors++;
            $display("FAIL bp_ct: got %h (valid=%b), required %h", ct0, ok, exp);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ct_out !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b ct=%h, required 1 0 %h", i, out_valid, in_ready, ct_out, exp);
            end
        end
        ack();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        logic [127:0] exp_q[$];
        logic [127:0] ct, exp;
        int sent = 0, done = 0;
        bit rdy, ov;
        pt_in = rnd128(); key_in = rnd128();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 200 && done < 4; c++) begin
            rdy = in_ready; ov = out_valid; ct = ct_out;
            if (ov) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_simul_ready: in_ready=%b while out_valid, required 0", in_ready);
                end
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++;
                if (ct !== exp) begin
                    errors++;
                    $display("FAIL b2b_ct%0d: got %h, required %h", done, ct, exp);
                end
                done++;
            end
            if (rdy && in_valid) begin
                exp_q.push_back(aes_model(pt_in, key_in, NR));
                acc_q.push_back(cyc + 1);
                sent++;
            end
            tick();
            if (rdy && in_valid) begin
                pt_in = rnd128(); key_in = rnd128();
                if (sent == 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (done != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 4", done);
        end
        for (int i = 0; i + 1 < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i+1] - acc_q[i] != NR + 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, acc_q[i+1] - acc_q[i], NR + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, vcyc; bit ok, seen; logic [127:0] ct, pt, key, exp;
        send(rnd128(), rnd128(), acc);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_spurious: out_valid seen=1, required 0");
        end
        pt = rnd128(); key = rnd128();
        exp = aes_model(pt, key, NR);
        send(pt, key, acc);
        wait_valid(ok, vcyc, ct);
        checks++;
        if (!ok || ct !== exp) begin
            errors++;
            $display("FAIL midreset_recover: got %h (valid=%b), required %h", ct, ok, exp);
        end
        ack();
    endtask

    task automatic test_ignore_busy();
        int acc, vcyc; bit ok, seen; logic [127:0] ct, pt, key, exp;
        pt = rnd128(); key = rnd128();
        exp = aes_model(pt, key, NR);
        send(pt, key, acc);
        repeat (3) tick();
        pt_in = ~pt; key_in = rnd128(); in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        wait_valid(ok, vcyc, ct);
        checks++;
        if (!ok || ct !== exp) begin
            errors++;
            $display("FAIL ignore_ct: got %h (valid=%b), required %h", ct, ok, exp);
        end
        ack();
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL ignore_extra_job: out_valid seen=1, required 0");
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_kat();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_ignore_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
